// File: rtl/bds_pkg.sv
// bds_pkg: shared definitions for the bds_deser slice.
//   - default word width and bit-counter width
//   - deserializer state encoding
//   - parity polarity used when BDS_PARITY_EN is defined
package bds_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_DISCARD = 2'd2
  } bds_state_e;

  // Even parity: XOR over data bits and the parity bit must equal this value.
  localparam logic PAR_EVEN = 1'b0;

endpackage

// File: rtl/bds_out_reg.sv
// bds_out_reg: one-word valid/ready holding register.
//   clk_a, rst_a : clock, synchronous active-high reset
//   load         : a completed word is offered this cycle
//   load_data    : the completed word
//   out_ready    : consumer accepts when out_valid & out_ready
//   out_data     : held word
//   out_valid    : held word is valid
//   ovf          : one-cycle pulse, offered word dropped because register full
//
// Handshake: a word transfers on a rising edge where out_valid & out_ready.
// out_valid and out_data stay stable until that transfer. A load on the
// transfer edge replaces the word with no bubble; a load while full and not
// accepted drops the new word and pulses ovf.
module bds_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk_a,
  input  logic             rst_a,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             ovf
);

  logic accept;
  assign accept = out_valid & out_ready;

  always_ff @(posedge clk_a) begin
    if (rst_a) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      ovf <= 1'b0;
      if (load) begin
        if (!out_valid || accept) begin
          out_data  <= load_data;
          out_valid <= 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bds_deser.sv
// bds_deser: checks the complementary bit pair (bds_1 true, bds_2 complement)
// and deserializes true bits MSB-first into WIDTH-bit words.
//   clk_a, rst_a   : clock, synchronous active-high reset
//   bds_1, bds_2   : true bit and its complement
//   bit_en         : qualifies bds_1/bds_2 this cycle
//   frm_sof        : with bit_en, this bit is the MSB of a new word
//   out_data/out_valid/out_ready : one-word valid/ready output
//   err_pair       : sticky pair error, cleared by rst_a or next frm_sof
//   err_frm        : pulse, frm_sof arrived mid-word
//   ovf            : pulse, completed word dropped (output full)
//   dbg_state      : current FSM state (bds_state_e encoding)
//   err_par        : (BDS_PARITY_EN only) pulse, parity mismatch, word dropped
// Optional feature macro: BDS_PARITY_EN adds a trailing even-parity bit per word.
module bds_deser
  import bds_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_a,
  input  logic             rst_a,
  input  logic             bds_1,
  input  logic             bds_2,
  input  logic             bit_en,
  input  logic             frm_sof,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_pair,
  output logic             err_frm,
  output logic             ovf,
`ifdef BDS_PARITY_EN
  output logic             err_par,
`endif
  output logic [1:0]       dbg_state
);

`ifdef BDS_PARITY_EN
  // Counter value of the trailing parity bit.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
`else
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
`endif

  bds_state_e       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_pair_q, err_pair_d;
  logic             err_frm_q, err_frm_d;
  logic             word_done;
  logic [WIDTH-1:0] done_word;
  logic             pair_bad;
  logic             last_bit;
`ifdef BDS_PARITY_EN
  logic             err_par_q, err_par_d;
`endif

  assign pair_bad = bit_en && (bds_1 == bds_2);
  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk_a) begin
    if (rst_a) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a pair error wins over frm_sof on the same bit.
  always_comb begin
    state_d = state_q;
    if (bit_en) begin
      if (pair_bad)     state_d = ST_DISCARD;
      else if (frm_sof) state_d = ST_SHIFT;
      else if (last_bit) state_d = ST_IDLE;
    end
  end

  // Datapath / output control
  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    err_pair_d = err_pair_q;
    err_frm_d  = 1'b0;
    word_done  = 1'b0;
`ifdef BDS_PARITY_EN
    err_par_d  = 1'b0;
    done_word  = shift_q;
`else
    done_word  = {shift_q[WIDTH-2:0], bds_1};
`endif
    if (bit_en) begin
      if (pair_bad) begin
        err_pair_d = 1'b1;
        shift_d    = '0;
        cnt_d      = '0;
      end else if (frm_sof) begin
        err_pair_d = 1'b0;
        err_frm_d  = (state_q == ST_SHIFT) && (cnt_q != '0);
        shift_d    = {{(WIDTH-1){1'b0}}, bds_1};
        cnt_d      = CNT_W'(1);
      end else if (state_q == ST_SHIFT) begin
        if (last_bit) begin
          shift_d = '0;
          cnt_d   = '0;
`ifdef BDS_PARITY_EN
          // Parity bit is not shifted; the data word is already complete.
          if ((^shift_q ^ bds_1) == PAR_EVEN) word_done = 1'b1;
          else                                err_par_d = 1'b1;
`else
          word_done = 1'b1;
`endif
        end else begin
          shift_d = {shift_q[WIDTH-2:0], bds_1};
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_a) begin
    if (rst_a) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      err_pair_q <= 1'b0;
      err_frm_q  <= 1'b0;
`ifdef BDS_PARITY_EN
      err_par_q  <= 1'b0;
`endif
    end else begin
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      err_pair_q <= err_pair_d;
      err_frm_q  <= err_frm_d;
`ifdef BDS_PARITY_EN
      err_par_q  <= err_par_d;
`endif
    end
  end

  bds_out_reg #(.WIDTH(WIDTH)) u_out_reg (
    .clk_a     (clk_a),
    .rst_a     (rst_a),
    .load      (word_done),
    .load_data (done_word),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

  assign err_pair  = err_pair_q;
  assign err_frm   = err_frm_q;
  assign dbg_state = state_q;
`ifdef BDS_PARITY_EN
  assign err_par   = err_par_q;
`endif

endmodule

// File: tb/tb_bds_deser.sv
module tb_bds_deser;

  localparam int WIDTH = 8;
`ifdef BDS_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  // ---------------- clock / reset ----------------
  logic clk_a = 1'b0;
  always #5 clk_a = ~clk_a;

  logic             rst_a = 1'b1;
  logic             bds_1 = 1'b0, bds_2 = 1'b1, bit_en = 1'b0, frm_sof = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid, err_pair, err_frm, ovf;
  logic             err_par;
  logic [1:0]       dbg_state;

  bds_deser #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk_a     (clk_a),
    .rst_a     (rst_a),
    .bds_1     (bds_1),
    .bds_2     (bds_2),
    .bit_en    (bit_en),
    .frm_sof   (frm_sof),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_pair  (err_pair),
    .err_frm   (err_frm),
    .ovf       (ovf),
`ifdef BDS_PARITY_EN
    .err_par   (err_par),
`endif
    .dbg_state (dbg_state)
  );
`ifndef BDS_PARITY_EN
  assign err_par = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame-level view: collected bits kept in a queue, word value computed
  // arithmetically once the frame length is reached.
  localparam int M_IDLE = 0, M_COLLECT = 1, M_DISCARD = 2;
  int               m_mode = M_IDLE;
  bit               m_bits[$];
  logic             m_valid = 0, m_err_pair = 0, m_err_frm = 0, m_ovf = 0, m_err_par = 0;
  logic [WIDTH-1:0] m_data = '0;

  task automatic model_next();
    bit   done, good, acc;
    int   ones;
    logic [WIDTH-1:0] word;
    if (rst_a) begin
      m_mode = M_IDLE; m_bits.delete();
      m_valid = 0; m_data = '0; m_err_pair = 0; m_err_frm = 0; m_ovf = 0; m_err_par = 0;
      return;
    end
    acc = m_valid && out_ready;
    done = 0; good = 1; word = '0;
    m_err_frm = 0; m_ovf = 0; m_err_par = 0;
    if (bit_en) begin
      if (bds_1 == bds_2) begin
        m_err_pair = 1; m_bits.delete(); m_mode = M_DISCARD;
      end else if (frm_sof) begin
        m_err_frm = (m_mode == M_COLLECT) && (m_bits.size() != 0);
        m_err_pair = 0; m_bits.delete(); m_bits.push_back(bds_1); m_mode = M_COLLECT;
      end else if (m_mode == M_COLLECT) begin
        m_bits.push_back(bds_1);
        if (m_bits.size() == NBITS) begin
          ones = 0;
          for (int i = 0; i < NBITS; i++) ones += int'(m_bits[i]);
          for (int i = 0; i < WIDTH; i++) word = word + (WIDTH'(m_bits[i]) << (WIDTH - 1 - i));
          good = (NBITS == WIDTH) || (ones % 2 == 0);
          done = 1; m_bits.delete(); m_mode = M_IDLE;
        end
      end
    end
    if (done && !good) m_err_par = 1;
    if (done && good) begin
      if (!m_valid || out_ready) begin m_data = word; m_valid = 1; end
      else m_ovf = 1;
    end else if (acc) begin
      m_valid = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_next();
    @(posedge clk_a);
    #1;
    chk("m_valid", out_valid, m_valid);
    chk("m_data", out_data, m_data);
    chk("m_err_pair", err_pair, m_err_pair);
    chk("m_err_frm", err_frm, m_err_frm);
    chk("m_ovf", ovf, m_ovf);
`ifdef BDS_PARITY_EN
    chk("m_err_par", err_par, m_err_par);
`endif
  endtask

  task automatic send_bit(input logic b, input logic sof, input logic bad);
    bit_en = 1; frm_sof = sof; bds_1 = b; bds_2 = bad ? b : ~b;
    tick();
    bit_en = 0; frm_sof = 0;
  endtask

  // Trailing parity bit; nothing is sent when parity is not built in.
  task automatic send_par(input logic [WIDTH-1:0] w, input logic flip);
`ifdef BDS_PARITY_EN
    send_bit((^w) ^ flip, 0, 0);
`else
    if (flip) $display("note: parity flip ignored in this build");
    if (w === 'x) $display("note: undefined word");
`endif
  endtask

  // Sends the first nb bits of w MSB-first; a full frame also gets its parity.
  task automatic send_frame(input logic [WIDTH-1:0] w, input int nb, input int bad_idx,
                            input bit gaps, input logic par_flip);
    for (int i = 0; i < nb; i++) begin
      send_bit(w[WIDTH-1-i], i == 0, i == bad_idx);
      if (gaps && i < nb - 1) begin
        bds_1 = 1'($urandom_range(0, 1)); bds_2 = bds_1;
        tick();
      end
    end
    if (nb == WIDTH) send_par(w, par_flip);
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [WIDTH-1:0] word;
    int               bad_idx;
    bit               gaps;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_data;
    logic             exp_err_pair;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'hA5, -1, 0, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h5A, -1, 1, 1'b1, 8'h5A, 1'b0};
    vecs[2] = '{8'h00, -1, 0, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, -1, 0, 1'b1, 8'hFF, 1'b0};
    vecs[4] = '{8'h77,  4, 0, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h0F, -1, 0, 1'b1, 8'h0F, 1'b0};

    // reset state
    rst_a = 1; tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_err_pair", err_pair, 0);
    chk("rst_err_frm", err_frm, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_state", dbg_state, 0);
    rst_a = 0; tick();

    // table-driven single frames, consumer always ready
    out_ready = 1;
    foreach (vecs[k]) begin
      send_frame(vecs[k].word, WIDTH, vecs[k].bad_idx, vecs[k].gaps, 0);
      chk($sformatf("vec%0d_valid", k), out_valid, vecs[k].exp_valid);
      if (vecs[k].exp_valid) chk($sformatf("vec%0d_data", k), out_data, vecs[k].exp_data);
      chk($sformatf("vec%0d_err_pair", k), err_pair, vecs[k].exp_err_pair);
      chk($sformatf("vec%0d_ovf", k), ovf, 0);
      tick();
      chk($sformatf("vec%0d_drop", k), out_valid, 0);
    end

    // overflow: 3C held, C3 dropped
    out_ready = 0;
    send_frame(8'h3C, WIDTH, -1, 0, 0);
    chk("ovf_first_valid", out_valid, 1);
    chk("ovf_first_data", out_data, 8'h3C);
    send_frame(8'hC3, WIDTH, -1, 0, 0);
    chk("ovf_pulse", ovf, 1);
    chk("ovf_held", out_data, 8'h3C);
    tick();
    chk("ovf_pulse_end", ovf, 0);
    chk("ovf_still_held", out_data, 8'h3C);
    out_ready = 1; tick();
    chk("ovf_accept", out_valid, 0);

    // misframe: sof after 5 bits, then 81
    send_frame(8'hFF, 5, -1, 0, 0);
    send_bit(1'b1, 1, 0);
    chk("frm_pulse", err_frm, 1);
    chk("frm_no_word", out_valid, 0);
    for (int i = 1; i < WIDTH; i++) begin
      send_bit(1'((8'h81 >> (WIDTH - 1 - i)) & 1), 0, 0);
      if (i == 1) chk("frm_pulse_end", err_frm, 0);
    end
    send_par(8'h81, 0);
    chk("frm_valid", out_valid, 1);
    chk("frm_data", out_data, 8'h81);
    tick();

    // completion coincident with acceptance: no bubble
    out_ready = 0;
    send_frame(8'h11, WIDTH, -1, 0, 0);
    send_frame(8'h22, WIDTH - 1, -1, 0, 0);
    chk("bb_held", out_data, 8'h11);
    out_ready = 1;
`ifdef BDS_PARITY_EN
    send_bit(1'b0, 0, 0);
    send_par(8'h22, 0);
`else
    send_bit(1'b0, 0, 0);
`endif
    chk("bb_valid", out_valid, 1);
    chk("bb_data", out_data, 8'h22);
    chk("bb_no_ovf", ovf, 0);
    tick();
    chk("bb_drop", out_valid, 0);

    // reset mid-frame with a held word
    out_ready = 0;
    send_frame(8'h12, WIDTH, -1, 0, 0);
    send_frame(8'h34, 3, -1, 0, 0);
    rst_a = 1; tick();
    chk("rst2_valid", out_valid, 0);
    chk("rst2_data", out_data, 0);
    chk("rst2_err", {err_pair, err_frm, ovf}, 0);
    rst_a = 0; out_ready = 1;
    send_frame(8'hFF, WIDTH, -1, 0, 0);
    chk("rst2_ff_valid", out_valid, 1);
    chk("rst2_ff_data", out_data, 8'hFF);
    tick();

`ifdef BDS_PARITY_EN
    send_frame(8'hA5, WIDTH, -1, 0, 1);
    chk("par_pulse", err_par, 1);
    chk("par_no_word", out_valid, 0);
    tick();
    chk("par_pulse_end", err_par, 0);
`endif

    // randomized phase against the model
    for (int c = 0; c < 3000; c++) begin
      rst_a     = ($urandom_range(0, 199) == 0);
      bit_en    = ($urandom_range(0, 9) < 7);
      frm_sof   = bit_en && ($urandom_range(0, 11) == 0);
      bds_1     = 1'($urandom_range(0, 1));
      bds_2     = ($urandom_range(0, 24) == 0) ? bds_1 : ~bds_1;
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bds_deser.md
Name: bds_deser

Overview:
- Downstream consumer of the complementary bit pair produced by the preceding register stage.
  - bds_1 is the true data bit.
  - bds_2 is its registered complement.
- Checks pair integrity on every qualified cycle.
- Deserializes true bits MSB-first into WIDTH-bit words.
- Presents each word on a valid/ready output held in a one-word output register.
- Flags pair errors, misframed words and overflow.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- CNT_W, 5, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk_a  in  1  sole clock; all state changes on its rising edge.
- rst_a  in  1  synchronous, active-high reset.
- bds_1  in  1  true data bit from upstream stage.
- bds_2  in  1  complement bit from upstream stage.
- bit_en  in  1  qualifies bds_1/bds_2 this cycle.
- frm_sof  in  1  start of frame; valid only with bit_en; the qualified bit is bit WIDTH-1 (MSB) of a new word.
- out_data  out  WIDTH  assembled word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- err_pair  out  1  sticky: bds_1 == bds_2 seen on a qualified cycle.
- err_frm  out  1  one-cycle pulse: frm_sof arrived before the current word completed.
- ovf  out  1  one-cycle pulse: completed word dropped because the output register was full.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high. Clock is clk_a, reset is rst_a.
- Reset values:
  - out_data = 0, out_valid = 0, err_pair = 0, err_frm = 0, ovf = 0.
  - Shift register = 0, counter = 0, state = IDLE.
- Reset mid-frame: partial word discarded. A held output word is dropped (out_valid = 0 the next cycle).
- States:
  - IDLE: waits for bit_en & frm_sof → SHIFT. Qualified bits without frm_sof are ignored.
  - SHIFT: each qualified cycle shifts bds_1 in and increments the counter. When counter reaches WIDTH-1 with bit_en, the word completes → IDLE.
  - DISCARD: entered on a pair error. Qualified bits are ignored until the next frm_sof → SHIFT.
- Pair check: on bit_en with bds_1 == bds_2:
  - err_pair set; stays set until rst_a or the next frm_sof;
  - current word abandoned; state → DISCARD.
- frm_sof in SHIFT with counter != 0:
  - err_frm pulses;
  - partial word dropped;
  - counter restarts with this bit as MSB.
- Completion latency: the completing bit is sampled at edge N; out_valid = 1 and out_data = word after edge N. One cycle of latency.
- Output register:
  - Holds its word until accepted.
  - out_valid drops the cycle after out_valid & out_ready, unless a new word completes that same cycle.
  - Completion coincident with acceptance: new word loads, out_valid stays 1 with no bubble and no ovf.
- Completion while out_valid & !out_ready: new word dropped, ovf pulses one cycle, held word unchanged.
- bit_en = 0: no state change; errors are not evaluated.
- Counter wraps to 0 on completion. No arithmetic beyond the CNT_W increment.

Optional Feature:
- Macro: BDS_PARITY_EN.
- Defined:
  - A frame carries WIDTH data bits plus one trailing even-parity bit.
  - Counter runs 0..WIDTH.
  - Parity mismatch drops the word and pulses extra output err_par (out, 1). No word is presented and ovf is not raised.
  - Completion latency is unchanged, measured from the parity bit.
- Undefined: no parity bit and no err_par port.

Decomposition:
- Shared package bds_pkg holds:
  - default WIDTH and CNT_W;
  - state encoding constants (IDLE = 2'd0, SHIFT = 2'd1, DISCARD = 2'd2);
  - parity-polarity constant.
- One natural sub-module: bds_out_reg, the one-word valid/ready holding register with drop/ovf logic.
- Shift/check/FSM logic stays in bds_deser.

Test Plan:
- Frame 8'hA5 with bit_en continuous, bds_2 = ~bds_1, out_ready = 1 → out_valid one cycle after the 8th bit, out_data = 8'hA5, no errors.
- Two back-to-back frames 8'h3C, 8'hC3 with out_ready = 0 until after the second completes → out_data = 8'h3C held, ovf pulses exactly one cycle at the second completion, 8'hC3 never appears.
- Bit 4 of a frame sent with bds_1 = bds_2 = 1 → err_pair set and held, no word output; next frm_sof frame 8'h0F → out_data = 8'h0F, err_pair cleared at that sof.
- frm_sof reasserted after 5 bits, then a full 8'h81 → err_frm pulses once, only 8'h81 presented.
- out_ready held high with completion on the same edge as acceptance → out_valid stays 1 continuously, both words delivered in order; bit_en gaps mid-frame do not alter 8'h5A.
- rst_a asserted after 3 bits and while a word is held → next cycle out_valid = 0, all outputs 0; following frame 8'hFF delivered correctly. With BDS_PARITY_EN, 8'hA5 + parity 1 → err_par pulse, no word.
